// File: rtl/clk_en_pkg.sv
// Shared constants, channel state encoding and divisor helper for the
// multi-channel clock-enable generator.
package clk_en_pkg;

    localparam int N_CH_DEF        = 4;
    localparam int DIV_W_DEF       = 16;
    localparam int LOCK_CYCLES_DEF = 16;

    // Widest divisor the helper below handles; channel DIV_W must not exceed it.
    localparam int DIV_MAX_W = 32;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // A programmed divisor of zero behaves like a divisor of one.
    function automatic logic [DIV_MAX_W-1:0] div_eff(input logic [DIV_MAX_W-1:0] div);
        return (div == '0) ? DIV_MAX_W'(1) : div;
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: a period counter with a shadowed divisor,
// a one-cycle tick at each wrap and a square strobe over the period.
module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ready_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             sq_o
);

    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]   ONE_X = (DIV_W + 1)'(1);

    // Length of the high phase: ceil(d/2), computed one bit wider so the
    // all-ones divisor cannot overflow.
    function automatic logic [DIV_W:0] half_up(input logic [DIV_W-1:0] d);
        return ({1'b0, d} + ONE_X) >> 1;
    endfunction

    ch_state_t        state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_act_q;
    logic             tick_q;
    logic             sq_q;

    logic [DIV_W-1:0] div_eff_d;
    logic [DIV_W-1:0] cnt_d;
    logic             wrap_d;
    logic             sq_d;

    // Free-running next count and strobe level for an undisturbed period.
    always_comb begin
        div_eff_d = DIV_W'(div_eff(DIV_MAX_W'(div_i)));
        wrap_d    = (cnt_q == (div_act_q - ONE));
        cnt_d     = wrap_d ? '0 : (cnt_q + ONE);
        sq_d      = ({1'b0, cnt_d} < half_up(div_act_q));
    end

    // Channel FSM; the divisor is only reloaded at entry, wrap or sync so a
    // period in progress is never shortened or stretched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            div_act_q <= ONE;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
        end else if (!ready_i || !en_i) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            sq_q    <= 1'b0;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    state_q   <= CH_RUN;
                    cnt_q     <= '0;
                    div_act_q <= div_eff_d;
                    tick_q    <= 1'b0;
                    sq_q      <= 1'b1;
                end
                CH_RUN: begin
                    if (sync_i) begin
                        // Restart in phase; a coincident wrap tick is dropped.
                        cnt_q     <= '0;
                        div_act_q <= div_eff_d;
                        tick_q    <= 1'b0;
                        sq_q      <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_d;
                        tick_q <= wrap_d;
                        sq_q   <= sq_d;
                        if (wrap_d) begin
                            div_act_q <= div_eff_d;
                        end
                    end
                end
                default: begin
                    state_q <= CH_IDLE;
                end
            endcase
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/clk_en_gen_multi.sv
// Multi-channel clock-enable generator: a post-reset settle window gates
// N_CH independent programmable tick/square channels.
module clk_en_gen_multi
    import clk_en_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic                    clk_ref,
    input  logic                    rst,
    input  logic [N_CH-1:0]         en_i,
    input  logic [N_CH*DIV_W-1:0]   div_i,
    input  logic                    sync_i,
    output logic                    ready_o,
    output logic [N_CH-1:0]         tick_o,
    output logic [N_CH-1:0]         sq_o
);

    localparam int                LOCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    logic [LOCK_W-1:0] lock_q;
    logic              ready_q;

    // Settle counter: ready rises at the LOCK_CYCLES-th edge after reset
    // release and then holds, so the counter stops once ready is set.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            lock_q  <= '0;
            ready_q <= 1'b0;
        end else if (!ready_q) begin
            lock_q <= lock_q + LOCK_W'(1);
            if (lock_q == LOCK_LAST) begin
                ready_q <= 1'b1;
            end
        end
    end

    assign ready_o = ready_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        clk_en_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk_i  (clk_ref),
            .rst_i  (rst),
            .ready_i(ready_q),
            .en_i   (en_i[k]),
            .sync_i (sync_i),
            .div_i  (div_i[k*DIV_W +: DIV_W]),
            .tick_o (tick_o[k]),
            .sq_o   (sq_o[k])
        );
    end

endmodule

// File: tb/tb_clk_en_gen_multi.sv
// Self-checking bench for clk_en_gen_multi: directed scenarios plus a
// randomized run, all compared against a period/phase reference model.
module tb_clk_en_gen_multi;

    localparam int N_CH  = 4;
    localparam int DIV_W = 16;
    localparam int LOCK  = 16;

    logic                  clk_ref = 1'b0;
    logic                  rst     = 1'b1;
    logic [N_CH-1:0]       en_i    = '0;
    logic [N_CH*DIV_W-1:0] div_i   = '0;
    logic                  sync_i  = 1'b0;
    logic                  ready_o;
    logic [N_CH-1:0]       tick_o;
    logic [N_CH-1:0]       sq_o;

    clk_en_gen_multi #(
        .N_CH(N_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK)
    ) dut (
        .clk_ref(clk_ref),
        .rst    (rst),
        .en_i   (en_i),
        .div_i  (div_i),
        .sync_i (sync_i),
        .ready_o(ready_o),
        .tick_o (tick_o),
        .sq_o   (sq_o)
    );

    always #5 clk_ref = ~clk_ref;

    int checks = 0;
    int errors = 0;

    // Reference model: each running channel tracks how many cycles have
    // elapsed in the current period and how long that period is.
    int              m_lock;
    bit              m_rdy;
    bit              m_run [N_CH];
    int              m_age [N_CH];
    int              m_per [N_CH];
    logic [N_CH-1:0] m_tick = '0;
    logic [N_CH-1:0] m_sq   = '0;

    function automatic int div_of(int k);
        int d;
        d = int'(div_i[k*DIV_W +: DIV_W]);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic set_div(int k, int v);
        div_i[k*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic model_edge();
        bit rdy_pre;
        int d;
        if (rst) begin
            m_lock = 0;
            m_rdy  = 0;
            for (int k = 0; k < N_CH; k++) begin
                m_run[k] = 0; m_age[k] = 0; m_per[k] = 1;
            end
            m_tick = '0;
            m_sq   = '0;
            return;
        end
        rdy_pre = m_rdy;
        if (!m_rdy) begin
            m_lock++;
            if (m_lock >= LOCK) m_rdy = 1;
        end
        for (int k = 0; k < N_CH; k++) begin
            d = div_of(k);
            if (!rdy_pre || !en_i[k]) begin
                m_run[k] = 0; m_tick[k] = 0; m_sq[k] = 0;
            end else if (!m_run[k] || sync_i) begin
                m_run[k] = 1; m_age[k] = 0; m_per[k] = d;
                m_tick[k] = 0; m_sq[k] = 1;
            end else begin
                m_age[k]++;
                m_tick[k] = (m_age[k] == m_per[k]);
                if (m_tick[k]) begin
                    m_age[k] = 0;
                    m_per[k] = d;
                end
                m_sq[k] = (m_age[k] < (m_per[k] + 1) / 2);
            end
        end
    endtask

    // Advance one clock, update the model at the edge, settle before sampling.
    task automatic cyc();
        @(posedge clk_ref);
        model_edge();
        #1;
    endtask

    // Hold channel k idle for one edge with divisor d; the next edge enters RUN.
    task automatic restart(int k, int d);
        en_i[k] = 1'b0;
        set_div(k, d);
        cyc();
        en_i[k] = 1'b1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en_i = '1;
        for (int k = 0; k < N_CH; k++) set_div(k, $urandom_range(1, 8));
        repeat (3) begin
            cyc();
            checks++;
            if (ready_o !== 1'b0 || tick_o !== '0 || sq_o !== '0) begin
                errors++;
                $display("FAIL reset_state ready=%b tick=%b sq=%b required 0/0/0", ready_o, tick_o, sq_o);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= LOCK + 6; i++) begin
            cyc();
            checks++;
            if (ready_o !== 1'(i >= LOCK)) begin
                errors++;
                $display("FAIL lock_window edge=%0d ready=%b required %b", i, ready_o, i >= LOCK);
            end
            if (i <= LOCK) begin
                checks++;
                if (tick_o !== '0 || sq_o !== '0) begin
                    errors++;
                    $display("FAIL idle_before_ready edge=%0d tick=%b sq=%b required 0/0", i, tick_o, sq_o);
                end
            end
            checks++;
            if (tick_o !== m_tick || sq_o !== m_sq || ready_o !== m_rdy) begin
                errors++;
                $display("FAIL model_reset t=%0t tick=%b/%b sq=%b/%b rdy=%b/%b", $time, tick_o, m_tick, sq_o, m_sq, ready_o, m_rdy);
            end
        end
    endtask

    task automatic test_div4();
        restart(0, 4);
        for (int j = 0; j < 16; j++) begin
            cyc();
            checks++;
            if (tick_o[0] !== 1'(j > 0 && j % 4 == 0) || sq_o[0] !== 1'(j % 4 < 2)) begin
                errors++;
                $display("FAIL div4 j=%0d tick=%b sq=%b required %b/%b", j, tick_o[0], sq_o[0], j > 0 && j % 4 == 0, j % 4 < 2);
            end
            checks++;
            if (tick_o !== m_tick || sq_o !== m_sq) begin
                errors++;
                $display("FAIL model_div4 j=%0d tick=%b/%b sq=%b/%b", j, tick_o, m_tick, sq_o, m_sq);
            end
        end
    endtask

    task automatic test_special_divs();
        en_i[3:1] = '0;
        set_div(1, 0);
        set_div(2, 1);
        set_div(3, 5);
        cyc();
        en_i[3:1] = '1;
        for (int j = 0; j < 15; j++) begin
            cyc();
            checks++;
            if (tick_o[1] !== 1'(j > 0) || tick_o[2] !== 1'(j > 0) || sq_o[1] !== 1'b1 || sq_o[2] !== 1'b1) begin
                errors++;
                $display("FAIL div0_div1 j=%0d tick=%b%b sq=%b%b required tick=%b sq=11", j, tick_o[1], tick_o[2], sq_o[1], sq_o[2], j > 0);
            end
            checks++;
            if (tick_o[3] !== 1'(j > 0 && j % 5 == 0) || sq_o[3] !== 1'(j % 5 < 3)) begin
                errors++;
                $display("FAIL div5 j=%0d tick=%b sq=%b required %b/%b", j, tick_o[3], sq_o[3], j > 0 && j % 5 == 0, j % 5 < 3);
            end
            checks++;
            if (tick_o !== m_tick || sq_o !== m_sq) begin
                errors++;
                $display("FAIL model_special j=%0d tick=%b/%b sq=%b/%b", j, tick_o, m_tick, sq_o, m_sq);
            end
        end
    endtask

    task automatic test_div_change();
        logic et;
        logic es;
        restart(0, 4);
        for (int j = 0; j < 20; j++) begin
            cyc();
            et = (j == 4 || j == 10 || j == 16);
            es = (j < 4) ? (j < 2) : ((j - 4) % 6 < 3);
            checks++;
            if (tick_o[0] !== et || sq_o[0] !== es) begin
                errors++;
                $display("FAIL div_change j=%0d tick=%b sq=%b required %b/%b", j, tick_o[0], sq_o[0], et, es);
            end
            checks++;
            if (tick_o !== m_tick || sq_o !== m_sq) begin
                errors++;
                $display("FAIL model_change j=%0d tick=%b/%b sq=%b/%b", j, tick_o, m_tick, sq_o, m_sq);
            end
            if (j == 1) set_div(0, 6);
        end
    endtask

    task automatic test_sync();
        logic et;
        logic es;
        for (int k = 1; k < N_CH; k++) set_div(k, $urandom_range(2, 9));
        en_i = '1;
        restart(0, 4);
        for (int j = 0; j < 13; j++) begin
            cyc();
            sync_i = (j == 3);
            et = (j == 8 || j == 12);
            es = (j < 4) ? (j % 4 < 2) : ((j - 4) % 4 < 2);
            checks++;
            if (tick_o[0] !== et || sq_o[0] !== es) begin
                errors++;
                $display("FAIL sync_ch0 j=%0d tick=%b sq=%b required %b/%b", j, tick_o[0], sq_o[0], et, es);
            end
            if (j == 4) begin
                checks++;
                if (tick_o !== '0 || sq_o !== '1) begin
                    errors++;
                    $display("FAIL sync_align tick=%b sq=%b required 0000/1111", tick_o, sq_o);
                end
            end
            checks++;
            if (tick_o !== m_tick || sq_o !== m_sq) begin
                errors++;
                $display("FAIL model_sync j=%0d tick=%b/%b sq=%b/%b", j, tick_o, m_tick, sq_o, m_sq);
            end
        end
        sync_i = 1'b0;
    endtask

    task automatic test_disable_at_wrap();
        logic et;
        logic es;
        restart(0, 4);
        for (int j = 0; j < 8; j++) begin
            cyc();
            et = 1'b0;
            es = (j < 4) ? (j < 2) : 1'b0;
            checks++;
            if (tick_o[0] !== et || sq_o[0] !== es) begin
                errors++;
                $display("FAIL disable_wrap j=%0d tick=%b sq=%b required %b/%b", j, tick_o[0], sq_o[0], et, es);
            end
            checks++;
            if (tick_o !== m_tick || sq_o !== m_sq) begin
                errors++;
                $display("FAIL model_disable j=%0d tick=%b/%b sq=%b/%b", j, tick_o, m_tick, sq_o, m_sq);
            end
            if (j == 3) en_i[0] = 1'b0;
        end
        en_i[0] = 1'b1;
    endtask

    task automatic test_rst_mid();
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if (ready_o !== 1'b0 || tick_o !== '0 || sq_o !== '0) begin
            errors++;
            $display("FAIL rst_mid ready=%b tick=%b sq=%b required 0/0/0", ready_o, tick_o, sq_o);
        end
        rst = 1'b0;
        for (int i = 1; i <= LOCK + 3; i++) begin
            cyc();
            checks++;
            if (ready_o !== 1'(i >= LOCK)) begin
                errors++;
                $display("FAIL relock edge=%0d ready=%b required %b", i, ready_o, i >= LOCK);
            end
            checks++;
            if (tick_o !== m_tick || sq_o !== m_sq || ready_o !== m_rdy) begin
                errors++;
                $display("FAIL model_relock edge=%0d tick=%b/%b sq=%b/%b rdy=%b/%b", i, tick_o, m_tick, sq_o, m_sq, ready_o, m_rdy);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            cyc();
            checks++;
            if (tick_o !== m_tick || sq_o !== m_sq || ready_o !== m_rdy) begin
                errors++;
                $display("FAIL model_random n=%0d tick=%b/%b sq=%b/%b rdy=%b/%b", n, tick_o, m_tick, sq_o, m_sq, ready_o, m_rdy);
            end
            for (int k = 0; k < N_CH; k++) begin
                if ($urandom_range(0, 15) == 0) en_i[k] = ~en_i[k];
                if ($urandom_range(0, 7) == 0) set_div(k, $urandom_range(0, 9));
            end
            sync_i = ($urandom_range(0, 19) == 0);
            rst    = ($urandom_range(0, 299) == 0);
        end
        sync_i = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_div4();
        test_special_divs();
        test_div_change();
        test_sync();
        test_disable_at_wrap();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_en_gen_multi.md
Name: clk_en_gen_multi

Overview:
- Parametrised successor to the board clock-generation wrapper. It runs entirely in the single 100 MHz domain and produces N_CH independent, runtime-programmable clock-enable ticks plus derived square-wave strobes, so downstream logic (UART, display scan, timers) needs no extra MMCM outputs.
- Provides a post-reset settle window with a ready flag (lock-style), per-channel enable, shadowed divisor update, and a global phase-align restart.

Parameters:
- N_CH, 4, number of independent channels.
- DIV_W, 16, divisor width per channel (period 1..2^DIV_W-1 cycles).
- LOCK_CYCLES, 16, cycles after reset release before ready_o asserts (>=1).

Ports:
- clk_ref  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  N_CH  per-channel run enable.
- div_i  in  N_CH*DIV_W  per-channel divisor; channel k uses bits [k*DIV_W +: DIV_W].
- sync_i  in  1  one-cycle pulse; restarts all enabled channels in phase.
- ready_o  out  1  settle window complete; channels may run.
- tick_o  out  N_CH  one-cycle enable pulse, once per divisor period.
- sq_o  out  N_CH  square strobe, high for the first ceil(div/2) cycles of each period.

Behaviour:
- Reset (rst=1 at an edge): lock counter=0, ready_o=0, all cnt=0, div_act=1, tick_o=0, sq_o=0. Applies identically mid-operation: everything restarts, including the lock window.
- Settle: the lock counter increments each cycle after rst is released. ready_o rises at the edge where the count reaches LOCK_CYCLES (ready_o is high LOCK_CYCLES cycles after the first edge with rst=0), then stays high until rst. While ready_o=0, channels are held idle (cnt=0, tick=0, sq=0) regardless of en_i.
- Effective divisor: div_eff = (div_i==0) ? 1 : div_i. A divisor of 0 is treated as 1.
- Channel states:
  - IDLE: entered when en_i=0 or ready_o=0. Holds cnt=0, tick_o=0, sq_o=0.
  - RUN: entered from IDLE at edge E where en_i=1 and ready_o=1. At E: div_act<=div_eff, cnt<=0, sq_o<=1. Each following edge: cnt<=(cnt==div_act-1) ? 0 : cnt+1.
- Tick: tick_o is registered. It is set at an edge where pre-edge cnt==div_act-1 and cleared otherwise. The first tick is high in the cycle after edge E+div_act, so there is exactly one tick per div_act cycles. div_act=1 gives tick_o high on every cycle from E+1.
- Square: sq_o is registered from the next cnt value: sq_o=1 iff next cnt < (div_act+1)>>1. div_act=1 gives sq_o constantly 1. An odd div has its high phase one cycle longer than its low phase.
- Divisor change: div_i is sampled into div_act only at wrap (cnt==div_act-1), on IDLE->RUN entry, or on sync_i. It is never sampled mid-period, so there are no runt periods.
- sync_i (with ready_o=1): every RUN channel sets cnt<=0, sq_o<=1, tick_o<=0, div_act<=div_eff. sync_i overrides a coincident wrap, so that tick is suppressed. sync_i has no effect on IDLE channels.
- Disable mid-period (en_i 1->0): at the next edge the channel goes to IDLE with cnt=0 and tick_o=0, even if that edge would have been a wrap.
- No combinational path exists from any input to any output.

Decomposition:
- Package clk_en_pkg holds: default constants for N_CH, DIV_W and LOCK_CYCLES; the channel state encoding (IDLE=0, RUN=1); and a function div_eff(div) implementing the zero-to-one mapping.
- One natural sub-module, clk_en_chan: a single channel (state, cnt, div_act, tick, sq). The top level holds the lock counter and ready_o and instantiates N_CH copies in a generate loop.

Test Plan:
- Reset release with LOCK_CYCLES=16, all en_i=1 -> ready_o=0 for 16 cycles, then 1; tick_o and sq_o stay 0 until ready_o is high.
- ch0 div=4, enabled at edge E -> tick_o[0] high in cycles E+4, E+8, E+12, ...; sq_o[0] pattern 1,1,0,0 repeating from E.
- ch1 div=0 and ch2 div=1 -> both tick_o high every cycle and sq_o constantly 1; ch3 div=5 -> sq_o pattern 1,1,1,0,0.
- ch0 div changed 4->6 at cnt=1 -> the current period still completes at 4 cycles; subsequent ticks are spaced 6 apart.
- sync_i pulsed on ch0's wrap cycle (div=4) -> no tick that cycle; the next tick follows 4 cycles after the sync edge; all enabled channels are realigned to cnt=0.
- rst asserted mid-run for 1 cycle -> all outputs 0 at the next edge; ready_o returns 16 cycles after release; en_i toggled 1->0 at a wrap -> no tick is emitted.
